// File: rtl/alu_wide_ctrl_pkg.sv
// Shared definitions: 8-bit ALU opcode encoding and the wide-sequencer state type.
package alu_wide_ctrl_pkg;

  localparam logic [3:0] kadd = 4'h0;
  localparam logic [3:0] kor  = 4'h1;
  localparam logic [3:0] kand = 4'h2;
  localparam logic [3:0] kbeq = 4'h3;
  localparam logic [3:0] kbnq = 4'h4;
  localparam logic [3:0] kblt = 4'h5;
  localparam logic [3:0] kbge = 4'h6;
  localparam logic [3:0] kbgt = 4'h7;
  localparam logic [3:0] klsl = 4'h8;
  localparam logic [3:0] klsr = 4'h9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EQH  = 3'd1,
    CMPH = 3'd2,
    LO   = 3'd3,
    HI   = 3'd4,
    RESP = 3'd5
  } alu_wide_state_t;

  // Ops that run low byte then high byte.
  function automatic logic is_two_pass(input logic [3:0] op);
    return (op == kadd) || (op == kor) || (op == kand) || (op == kbeq) || (op == kbnq);
  endfunction

  // Unsigned ordering compares: high-byte equality and compare first, then low byte.
  function automatic logic is_ord(input logic [3:0] op);
    return (op == kblt) || (op == kbge) || (op == kbgt);
  endfunction

endpackage

// File: rtl/alu_wide_ctrl.sv
// Sequences 16-bit ops over the parent-level 8-bit ALU. Optional ALU_WIDE_STALL_CNT_EN
// adds o_stall_cnt, counting RESP cycles with the response back-pressured.
module alu_wide_ctrl
  import alu_wide_ctrl_pkg::*;
#(
  parameter bit ERR_ON_UNSUPPORTED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [15:0] i_req_a,
  input  logic [15:0] i_req_b,
  input  logic        i_req_cin,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_carry,
  output logic        o_rsp_flag,
  output logic        o_rsp_err,
  output logic [7:0]  o_alu_input,
  output logic [7:0]  o_alu_accum,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_set,
  output logic        o_alu_sc_in,
  input  logic [7:0]  i_alu_out,
  input  logic        i_alu_sc_out,
  input  logic        i_alu_eq
`ifdef ALU_WIDE_STALL_CNT_EN
  ,
  output logic [15:0] o_stall_cnt
`endif
);

  alu_wide_state_t r_state;
  logic [3:0]  r_op;
  logic [15:0] r_a, r_b;
  logic [7:0]  r_lo_data;
  logic        r_lo_flag, r_hi_eq, r_hi_cmp;

  logic        r_req_ready, r_rsp_valid, r_rsp_carry, r_rsp_flag, r_rsp_err;
  logic [15:0] r_rsp_data;
  logic [7:0]  r_alu_input, r_alu_accum;
  logic [3:0]  r_alu_op;
  logic        r_alu_sc_in;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_lo_data   <= '0;
      r_lo_flag   <= 1'b0;
      r_hi_eq     <= 1'b0;
      r_hi_cmp    <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_flag  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_alu_input <= '0;
      r_alu_accum <= '0;
      r_alu_op    <= '0;
      r_alu_sc_in <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_op        <= i_req_op;
            r_a         <= i_req_a;
            r_b         <= i_req_b;
            r_req_ready <= 1'b0;
            if (is_two_pass(i_req_op)) begin
              r_state     <= LO;
              r_alu_input <= i_req_a[7:0];
              r_alu_accum <= i_req_b[7:0];
              r_alu_op    <= i_req_op;
              r_alu_sc_in <= (i_req_op == kadd) ? i_req_cin : 1'b0;
            end else if (is_ord(i_req_op)) begin
              r_state     <= EQH;
              r_alu_input <= i_req_a[15:8];
              r_alu_accum <= i_req_b[15:8];
              r_alu_op    <= kbeq;
              r_alu_sc_in <= 1'b0;
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_carry <= 1'b0;
              r_rsp_flag  <= 1'b0;
              r_rsp_err   <= ERR_ON_UNSUPPORTED;
            end
          end
        end
        EQH: begin
          r_hi_eq  <= i_alu_eq;
          r_alu_op <= r_op;
          r_state  <= CMPH;
        end
        CMPH: begin
          r_hi_cmp    <= i_alu_eq;
          r_alu_input <= r_a[7:0];
          r_alu_accum <= r_b[7:0];
          r_state     <= LO;
        end
        LO: begin
          r_lo_data <= i_alu_out;
          r_lo_flag <= i_alu_eq;
          if (is_ord(r_op)) begin
            // High bytes equal: the low byte decides; otherwise the high compare does.
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_flag  <= r_hi_eq ? i_alu_eq : r_hi_cmp;
            r_rsp_err   <= 1'b0;
            r_alu_input <= '0;
            r_alu_accum <= '0;
            r_alu_op    <= '0;
            r_alu_sc_in <= 1'b0;
          end else begin
            r_state     <= HI;
            r_alu_input <= r_a[15:8];
            r_alu_accum <= r_b[15:8];
            r_alu_sc_in <= i_alu_sc_out;
          end
        end
        HI: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= {i_alu_out, r_lo_data};
          r_rsp_carry <= (r_op == kadd) ? i_alu_sc_out : 1'b0;
          r_rsp_flag  <= (r_op == kbeq) ? (r_lo_flag & i_alu_eq) :
                         (r_op == kbnq) ? (r_lo_flag | i_alu_eq) : 1'b0;
          r_rsp_err   <= 1'b0;
          r_alu_input <= '0;
          r_alu_accum <= '0;
          r_alu_op    <= '0;
          r_alu_sc_in <= 1'b0;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_flag  <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_WIDE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_stall_cnt <= '0;
    else if (r_state == RESP && !i_rsp_ready && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_carry = r_rsp_carry;
  assign o_rsp_flag  = r_rsp_flag;
  assign o_rsp_err   = r_rsp_err;
  assign o_alu_input = r_alu_input;
  assign o_alu_accum = r_alu_accum;
  assign o_alu_op    = r_alu_op;
  assign o_alu_set   = 1'b0;
  assign o_alu_sc_in = r_alu_sc_in;

endmodule

// File: tb/tb_alu_wide_ctrl.sv
// Directed bench for alu_wide_ctrl with a behavioural 8-bit ALU beside it.
module tb_alu_wide_ctrl;
  import alu_wide_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic        req_cin = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_carry, rsp_flag, rsp_err;
  logic [7:0]  alu_input, alu_accum, alu_out;
  logic [3:0]  alu_op;
  logic        alu_set, alu_sc_in, alu_sc_out, alu_eq;
`ifdef ALU_WIDE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_stall = 0;
  logic lo_sc_out, hi_sc_in;

  always #5 clk = ~clk;

  alu_wide_ctrl #(.ERR_ON_UNSUPPORTED(1'b1)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_cin(req_cin),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_carry(rsp_carry), .o_rsp_flag(rsp_flag), .o_rsp_err(rsp_err),
    .o_alu_input(alu_input), .o_alu_accum(alu_accum), .o_alu_op(alu_op),
    .o_alu_set(alu_set), .o_alu_sc_in(alu_sc_in),
    .i_alu_out(alu_out), .i_alu_sc_out(alu_sc_out), .i_alu_eq(alu_eq)
`ifdef ALU_WIDE_STALL_CNT_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  // Reference 8-bit ALU: INPUT is the left operand of compares.
  always_comb begin
    alu_out    = 8'h00;
    alu_sc_out = 1'b0;
    alu_eq     = 1'b0;
    case (alu_op)
      kadd: {alu_sc_out, alu_out} = {1'b0, alu_input} + {1'b0, alu_accum} + {8'h00, alu_sc_in};
      kor:  alu_out = alu_input | alu_accum;
      kand: alu_out = alu_input & alu_accum;
      kbeq: alu_eq = (alu_input == alu_accum);
      kbnq: alu_eq = (alu_input != alu_accum);
      kblt: alu_eq = (alu_input <  alu_accum);
      kbge: alu_eq = (alu_input >= alu_accum);
      kbgt: alu_eq = (alu_input >  alu_accum);
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input int exp_lat,
                        input logic [15:0] ed, input logic ec, input logic ef,
                        input logic ee, input int stall);
    int lat;
    logic seen;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(posedge clk); #1;
    // Post-accept changes must be ignored.
    req_valid = 1'b0; req_op = kand; req_a = ~a; req_b = ~b; req_cin = ~cin;
    seen = 1'b0; lat = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) lo_sc_out = alu_sc_out;
      if (c == 2) hi_sc_in = alu_sc_in;
      if (rsp_valid) begin seen = 1'b1; lat = c; end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_carry"}, rsp_carry, ec);
    chk({tag, "_flag"}, rsp_flag, ef);
    chk({tag, "_err"}, rsp_err, ee);
    chk({tag, "_alu_idle"}, {alu_op, alu_input, alu_accum, alu_sc_in}, 21'h0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_hold"}, {rsp_valid, req_ready, rsp_data}, {1'b1, 1'b0, ed});
    end
    exp_stall += stall;
`ifdef ALU_WIDE_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
`endif
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    logic saw_valid;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_carry, rsp_flag, rsp_err}, 20'h0);
    chk("rst_alu", {alu_op, alu_input, alu_accum, alu_set, alu_sc_in}, 22'h0);
    @(negedge clk); reset_n = 1'b1;

    run_op("add_lo_carry", kadd, 16'h00FF, 16'h0001, 1'b0, 3, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
    chk("add_lo_sc_out", lo_sc_out, 1'b1);
    chk("add_hi_sc_in", hi_sc_in, 1'b1);
    run_op("add_wrap", kadd, 16'hFFFF, 16'h0001, 1'b0, 3, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    run_op("add_cin", kadd, 16'h1234, 16'h0FCD, 1'b1, 3, 16'h2202, 1'b0, 1'b0, 1'b0, 0);
    run_op("or", kor, 16'h00F0, 16'h0F0F, 1'b0, 3, 16'h0FFF, 1'b0, 1'b0, 1'b0, 0);
    run_op("and", kand, 16'hF0F0, 16'hFF00, 1'b1, 3, 16'hF000, 1'b0, 1'b0, 1'b0, 0);

    run_op("blt_hi", kblt, 16'h0105, 16'h0203, 1'b0, 4, 16'h0, 1'b0, 1'b1, 1'b0, 0);
    run_op("blt_lo", kblt, 16'h0205, 16'h0203, 1'b0, 4, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("bge_lo", kbge, 16'h0205, 16'h0203, 1'b0, 4, 16'h0, 1'b0, 1'b1, 1'b0, 0);
    run_op("bgt_eq", kbgt, 16'h0203, 16'h0203, 1'b0, 4, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("bgt_hi", kbgt, 16'h0300, 16'h02FF, 1'b0, 4, 16'h0, 1'b0, 1'b1, 1'b0, 0);

    run_op("beq_eq", kbeq, 16'h1234, 16'h1234, 1'b0, 3, 16'h0, 1'b0, 1'b1, 1'b0, 0);
    run_op("beq_ne", kbeq, 16'h1235, 16'h1234, 1'b0, 3, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("bnq_eq", kbnq, 16'h1234, 16'h1234, 1'b0, 3, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("bnq_ne", kbnq, 16'h1235, 16'h1234, 1'b0, 3, 16'h0, 1'b0, 1'b1, 1'b0, 0);

    run_op("stall", kadd, 16'h0001, 16'h0001, 1'b0, 3, 16'h0002, 1'b0, 1'b0, 1'b0, 5);
    run_op("unsup", klsl, 16'hABCD, 16'h1111, 1'b0, 1, 16'h0, 1'b0, 1'b0, 1'b1, 0);

    // Reset while in HI: back to IDLE, in-flight response dropped.
    @(negedge clk);
    req_valid = 1'b1; req_op = kadd; req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_hi_sc_path", alu_input, 8'h11);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_idle", {rsp_valid, req_ready}, 2'b01);
    @(negedge clk); reset_n = 1'b1;
    exp_stall = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("rst_mid_no_rsp", saw_valid, 1'b0);
    run_op("after_rst", kor, 16'hA000, 16'h0005, 1'b0, 3, 16'hA005, 1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_wide_ctrl.md
Name: alu_wide_ctrl

Overview:
- Initiator-side sequencer that drives the combinational 8-bit ALU to execute 16-bit operations over multiple cycles.
- Accepts a 16-bit request over a valid/ready handshake and issues the byte-wise ALU operations in sequence.
- Chains the ALU carry and compare flag between byte operations and returns a 16-bit result over a valid/ready response.
- Sits between the core decode stage and the ALU instance, which is instantiated at the parent level.

Parameters:
ERR_ON_UNSUPPORTED, 1, 1: unsupported opcode sets RSP_ERR; 0: returns zero data with RSP_ERR=0

Ports:
CLK  in  1  clock
RESET_N  in  1  reset, synchronous, active-low
REQ_VALID  in  1  request valid
REQ_READY  out  1  request accepted when high with REQ_VALID
REQ_OP  in  4  opcode (definitions package encoding)
REQ_A  in  16  operand routed to ALU INPUT
REQ_B  in  16  operand routed to ALU ACCUM
REQ_CIN  in  1  carry-in for kadd
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumed
RSP_DATA  out  16  result
RSP_CARRY  out  1  carry out of bit 15 (kadd only, else 0)
RSP_FLAG  out  1  16-bit compare result (compare ops only, else 0)
RSP_ERR  out  1  unsupported opcode
ALU_INPUT  out  8  to ALU INPUT
ALU_ACCUM  out  8  to ALU ACCUM
ALU_OP  out  4  to ALU OP
ALU_SET  out  1  to ALU SET, constant 0
ALU_SC_IN  out  1  to ALU SC_IN
ALU_OUT  in  8  from ALU
ALU_SC_OUT  in  1  from ALU
ALU_EQ  in  1  from ALU

Behaviour:
- Clocking and reset: one clock, CLK; reset is synchronous and active-low on RESET_N.
- Reset values: state=IDLE; REQ_READY=1; RSP_VALID, RSP_DATA, RSP_CARRY, RSP_FLAG, RSP_ERR all 0; ALU_* outputs 0.
- States: IDLE, EQH, CMPH, LO, HI, RESP.
- IDLE:
  - REQ_READY=1 only here.
  - On REQ_VALID, capture OP, A, B and CIN.
  - kadd/kor/kand go to LO. kbeq/kbnq go to LO. kblt/kbge/kbgt go to EQH. Any other opcode goes to RESP with data 0 and RSP_ERR per parameter.
- LO: drive A[7:0], B[7:0] and OP; SC_IN = CIN for kadd, else 0. Register ALU_OUT into data[7:0], ALU_SC_OUT into the carry register and ALU_EQ into lo_flag. Go to HI.
- HI: drive A[15:8], B[15:8] and OP; SC_IN = registered lo carry. Register data[15:8]. Go to RESP.
  - kadd: RSP_CARRY = ALU_SC_OUT.
  - kbeq: flag = lo_flag AND ALU_EQ.
  - kbnq: flag = lo_flag OR ALU_EQ.
- EQH: drive the high bytes with OP=kbeq; register hi_eq. Go to CMPH.
- CMPH: drive the high bytes with the request OP; register hi_cmp. Go to LO. After LO, the final flag is lo_flag when hi_eq=1, else hi_cmp, and the state goes directly to RESP (HI is skipped). RSP_DATA = 0 for compares.
- RESP: RSP_VALID=1, all RSP_* held stable. On RSP_READY, go to IDLE next cycle; the next request is accepted no earlier than that cycle.
- Latency from the accept edge to RSP_VALID:
  - kadd/or/and/beq/bnq: 3 cycles.
  - blt/bge/bgt: 4 cycles.
  - unsupported: 1 cycle.
- Compares are unsigned.
- ALU_* outputs are 0 in IDLE and RESP.
- REQ_* changes after accept are ignored.
- RESET_N low in any state: return to IDLE next edge; any in-flight or pending response is dropped with no RSP_VALID pulse.

Optional Feature:
- ALU_WIDE_STALL_CNT_EN defined: adds output STALL_CNT[15:0].
  - Counts cycles in RESP with RSP_READY=0.
  - Saturates at 16'hFFFF; cleared by reset only.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Opcode constants (kadd, kor, kand, kbeq, kbnq, kblt, kbge, kbgt) stay in the shared definitions package.
- Add the state enum typedef (alu_wide_state_t) to the same package.
- No sub-module: a single FSM with datapath registers. The ALU is instantiated beside this block in the parent.

Test Plan:
1. kadd A=16'h00FF, B=16'h0001, CIN=0 -> RSP_DATA=16'h0100, CARRY=0, RSP_VALID 3 cycles after accept; LO cycle ALU_SC_OUT=1 drives HI ALU_SC_IN=1.
2. kadd A=16'hFFFF, B=16'h0001, CIN=0 -> RSP_DATA=16'h0000, CARRY=1.
3. kblt A=16'h0105, B=16'h0203 -> FLAG=1 (decided by high byte). Then kblt A=16'h0205, B=16'h0203 -> FLAG=0 (high equal, low 05<03 false). Each has 4-cycle latency.
4. kbeq A=B=16'h1234 -> FLAG=1. Then A=16'h1235 -> FLAG=0. kbnq with the same two operand pairs -> FLAG 0 then 1.
5. Hold RSP_READY=0 for 5 cycles -> RSP_VALID and RSP_DATA stable and REQ_READY=0 throughout; STALL_CNT=5 when the macro is defined.
6. Unsupported opcode (klsl) -> RSP_ERR=1, data 0, 1-cycle latency. Separately, RESET_N low during HI -> IDLE next cycle, no RSP_VALID pulse, REQ_READY=1.
